aes_block_sequencer: RTL and testbench

- Upstream control stage for cyphertext_memory. It walks a plaintext buffer block by block and launches the AES-128 core once per block.
- When the core finishes a block, it drives `pc_o`, `finish_d_o` and `cyphertext_d_o` straight into the cyphertext memory write port (`pc_i`, `finish_d`, `cyphertext_d`).
- It provides run-level start/done/error signalling and a per-block watchdog.

---
 rtl/aes_block_sequencer_pkg.sv | 21 ++
 rtl/aes_block_sequencer_if.sv | 40 ++++
 rtl/aes_block_sequencer_watchdog.sv | 39 +++
 rtl/aes_block_sequencer.sv | 156 +++++++++++++++
 tb/tb_aes_block_sequencer.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_block_sequencer_pkg.sv
// Shared definitions for the AES block sequencer: default geometry,
// default watchdog limit and the sequencer state encoding.
package aes_block_sequencer_pkg;

  localparam int unsigned AES_ADDR_WIDTH     = 8;
  localparam int unsigned AES_TEXT_WIDTH     = 128;
  localparam int unsigned AES_MEMORY_SIZE    = 256;
  localparam int unsigned AES_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_LAUNCH  = 3'd3,
    S_WAIT    = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

endpackage

// File: rtl/aes_block_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours.
//   plaintext read port : pt_addr_o, pt_rd_o -> ; <- pt_rdata_i
//   AES core handshake  : aes_start_o, aes_plaintext_o -> ; <- aes_done_i, aes_cyphertext_i
//   cyphertext write    : pc_o, finish_d_o, cyphertext_d_o ->
// master = sequencer side, slave = memory/core side.
interface aes_block_sequencer_if
  import aes_block_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AES_ADDR_WIDTH,
  parameter int unsigned TEXT_WIDTH = AES_TEXT_WIDTH
);

  logic [ADDR_WIDTH-1:0] pt_addr_o;
  logic                  pt_rd_o;
  logic [TEXT_WIDTH-1:0] pt_rdata_i;
  logic                  aes_start_o;
  logic [TEXT_WIDTH-1:0] aes_plaintext_o;
  logic                  aes_done_i;
  logic [TEXT_WIDTH-1:0] aes_cyphertext_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  finish_d_o;
  logic [TEXT_WIDTH-1:0] cyphertext_d_o;

  modport master (
    output pt_addr_o, pt_rd_o,
    input  pt_rdata_i,
    output aes_start_o, aes_plaintext_o,
    input  aes_done_i, aes_cyphertext_i,
    output pc_o, finish_d_o, cyphertext_d_o
  );

  modport slave (
    input  pt_addr_o, pt_rd_o,
    output pt_rdata_i,
    input  aes_start_o, aes_plaintext_o,
    output aes_done_i, aes_cyphertext_i,
    input  pc_o, finish_d_o, cyphertext_d_o
  );

endinterface

// File: rtl/aes_block_sequencer_watchdog.sv
// Per-block watchdog counter.
//   clk_i, rst_n_i : clock, async active-low reset
//   i_clr          : synchronous clear (block launch)
//   i_en           : count enable (waiting on the core)
//   o_timeout_c    : high in the enabled cycle whose increment reaches
//                    TIMEOUT_CYCLES-1
module aes_block_sequencer_watchdog
  import aes_block_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = AES_TIMEOUT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic i_clr,
  input  logic i_en,
  output logic o_timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc   = r_cnt + CNT_W'(1);
  assign o_timeout_c = i_en && (w_cnt_inc == LP_LAST);

  // Saturates at the limit so a stalled enable can never wrap back to zero.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (w_cnt_inc <= LP_LAST)) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/aes_block_sequencer.sv
// Walks a plaintext buffer block by block, launches the AES core once per
// block and writes each result into the cyphertext memory.
//   clk_i, rst_n_i : clock, async active-low reset
//   start_i        : run request (honoured in IDLE and ERROR)
//   num_blocks_i   : blocks in the run, clamped to MEMORY_SIZE
//   bus            : plaintext read, AES handshake, cyphertext write
//   busy_o         : FSM not in IDLE
//   done_o         : one-cycle pulse at end of a successful run
//   error_o        : sticky watchdog error
module aes_block_sequencer
  import aes_block_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AES_ADDR_WIDTH,
  parameter int unsigned TEXT_WIDTH     = AES_TEXT_WIDTH,
  parameter int unsigned MEMORY_SIZE    = AES_MEMORY_SIZE,
  parameter int unsigned TIMEOUT_CYCLES = AES_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   num_blocks_i,
  aes_block_sequencer_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LP_MEM_SIZE = CNT_W'(MEMORY_SIZE);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [CNT_W-1:0]      r_count;
  logic [ADDR_WIDTH-1:0] r_pt_addr;
  logic                  r_pt_rd;
  logic                  r_aes_start;
  logic [TEXT_WIDTH-1:0] r_aes_pt;
  logic [ADDR_WIDTH-1:0] r_pc_o;
  logic                  r_finish;
  logic [TEXT_WIDTH-1:0] r_ct;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;

  logic [CNT_W-1:0]      w_count_clamped;
  logic                  w_last_block;
  logic                  w_wd_clr;
  logic                  w_wd_en;
  logic                  w_timeout;

  assign w_count_clamped = (num_blocks_i > LP_MEM_SIZE) ? LP_MEM_SIZE : num_blocks_i;
  // Compared one bit wider than pc so a full-depth run ends at MEMORY_SIZE-1.
  assign w_last_block    = ({1'b0, r_pc} == (r_count - CNT_W'(1)));
  assign w_wd_clr        = (r_state == S_LAUNCH);
  assign w_wd_en         = (r_state == S_WAIT);

  aes_block_sequencer_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .i_clr       (w_wd_clr),
    .i_en        (w_wd_en),
    .o_timeout_c (w_timeout)
  );

  // Sequencer FSM; every output register is loaded on entry to the state
  // that owns it, so strobes line up with the state they belong to.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_count     <= '0;
      r_pt_addr   <= '0;
      r_pt_rd     <= 1'b0;
      r_aes_start <= 1'b0;
      r_aes_pt    <= '0;
      r_pc_o      <= '0;
      r_finish    <= 1'b0;
      r_ct        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_pt_rd     <= 1'b0;
      r_aes_start <= 1'b0;
      r_finish    <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start_i) begin
            r_error <= 1'b0;
            r_busy  <= 1'b1;
            if (w_count_clamped != '0) begin
              r_count   <= w_count_clamped;
              r_pc      <= '0;
              r_pt_addr <= '0;
              r_pt_rd   <= 1'b1;
              r_state   <= S_FETCH;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_aes_pt    <= bus.pt_rdata_i;
          r_aes_start <= 1'b1;
          r_state     <= S_LAUNCH;
        end
        S_LAUNCH: r_state <= S_WAIT;
        S_WAIT: begin
          // A done arriving in the timeout cycle still completes the block.
          if (bus.aes_done_i) begin
            r_ct     <= bus.aes_cyphertext_i;
            r_pc_o   <= r_pc;
            r_finish <= 1'b1;
            r_state  <= S_WRITE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_state <= S_ERROR;
          end
        end
        S_WRITE: begin
          if (w_last_block) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_pc      <= r_pc + ADDR_WIDTH'(1);
            r_pt_addr <= r_pc + ADDR_WIDTH'(1);
            r_pt_rd   <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.pt_addr_o       = r_pt_addr;
  assign bus.pt_rd_o         = r_pt_rd;
  assign bus.aes_start_o     = r_aes_start;
  assign bus.aes_plaintext_o = r_aes_pt;
  assign bus.pc_o            = r_pc_o;
  assign bus.finish_d_o      = r_finish;
  assign bus.cyphertext_d_o  = r_ct;
  assign busy_o              = r_busy;
  assign done_o              = r_done;
  assign error_o             = r_error;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: plaintext memory and AES core models, a
// transaction scoreboard fed from run-level expectations, and directed runs.
module tb_aes_block_sequencer;
  import aes_block_sequencer_pkg::*;

  localparam int unsigned AW = AES_ADDR_WIDTH;
  localparam int unsigned TW = AES_TEXT_WIDTH;
  localparam int unsigned MS = AES_MEMORY_SIZE;
  localparam int unsigned TO = AES_TIMEOUT_CYCLES;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_blocks = '0;
  logic          busy;
  logic          done;
  logic          error;

  aes_block_sequencer_if #(.ADDR_WIDTH(AW), .TEXT_WIDTH(TW)) bus ();

  aes_block_sequencer #(
    .ADDR_WIDTH     (AW),
    .TEXT_WIDTH     (TW),
    .MEMORY_SIZE    (MS),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .num_blocks_i (num_blocks),
    .bus          (bus),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void chk(input string name, input logic [127:0] got,
                              input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic void chki(input string name, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endfunction

  // Stand-in cipher; the reference vector maps to its published result.
  function automatic logic [127:0] aes_ref(input logic [127:0] pt);
    if (pt == PT0) return CT0;
    return {pt[63:0], pt[127:64]} ^ 128'hdeadbeef_0badf00d_12345678_9abcdef0;
  endfunction

  // ---------------- plaintext memory: data one cycle after the read strobe
  logic [TW-1:0] pt_mem [MS];
  always @(posedge clk) begin
    if (bus.pt_rd_o) bus.pt_rdata_i <= pt_mem[bus.pt_addr_o];
    else             bus.pt_rdata_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  // ---------------- AES core model: done in the aes_lat-th cycle after start
  int            aes_lat = 10;
  bit            aes_never = 1'b0;
  bit            spur_done = 1'b0;
  int            aes_k = 0;
  logic [TW-1:0] aes_held;
  logic          aes_done_q;
  logic [TW-1:0] aes_ct_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aes_k = 0;
      aes_done_q <= 1'b0;
      aes_ct_q <= '0;
    end else begin
      aes_done_q <= 1'b0;
      aes_ct_q <= {$urandom, $urandom, $urandom, $urandom};
      if (bus.aes_start_o && !aes_never) begin
        aes_held = bus.aes_plaintext_o;
        aes_k = aes_lat;
      end
      if (aes_k > 0) begin
        aes_k = aes_k - 1;
        if (aes_k == 0) begin
          aes_done_q <= 1'b1;
          aes_ct_q <= aes_ref(aes_held);
        end
      end
    end
  end
  assign bus.aes_done_i       = aes_done_q | spur_done;
  assign bus.aes_cyphertext_i = aes_ct_q;

  // ---------------- run-level model: what a run must produce
  logic [AW-1:0] exp_addr[$];
  logic [TW-1:0] exp_launch[$];
  logic [AW-1:0] exp_wr_pc[$];
  logic [TW-1:0] exp_wr_ct[$];
  int            exp_done = 0;

  task automatic expect_run(input int n);
    int nc;
    nc = (n > int'(MS)) ? int'(MS) : n;
    for (int i = 0; i < nc; i++) begin
      exp_addr.push_back(AW'(i));
      exp_launch.push_back(pt_mem[i]);
      exp_wr_pc.push_back(AW'(i));
      exp_wr_ct.push_back(aes_ref(pt_mem[i]));
    end
    exp_done++;
  endtask

  task automatic expect_stall();
    exp_addr.push_back('0);
    exp_launch.push_back(pt_mem[0]);
  endtask

  task automatic clear_model();
    exp_addr.delete();
    exp_launch.delete();
    exp_wr_pc.delete();
    exp_wr_ct.delete();
    exp_done = 0;
  endtask

  task automatic check_drained(input string name);
    chki({name, " outstanding expectations"},
         exp_addr.size() + exp_launch.size() + exp_wr_pc.size() + exp_done, 0);
  endtask

  // ---------------- compare process
  int            launch_cyc = 0;
  int            done_cyc = 0;
  int            n_wr = 0;
  int            fin_cyc[$];
  logic [AW-1:0] last_wr_pc = '0;
  logic          prev_fin = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pt_rd_o) begin
        if (exp_addr.size() == 0) chk("unexpected pt_rd_o", 128'(1), 128'(0));
        else chk("pt_addr_o", 128'(bus.pt_addr_o), 128'(exp_addr.pop_front()));
      end
      if (bus.aes_start_o) begin
        launch_cyc = cyc;
        if (exp_launch.size() == 0) chk("unexpected aes_start_o", 128'(1), 128'(0));
        else chk("aes_plaintext_o", bus.aes_plaintext_o, exp_launch.pop_front());
      end
      if (bus.finish_d_o) begin
        fin_cyc.push_back(cyc);
        n_wr++;
        last_wr_pc = bus.pc_o;
        chk("finish_d_o single cycle", 128'(prev_fin), 128'(0));
        if (exp_wr_pc.size() == 0) begin
          chk("unexpected finish_d_o", 128'(1), 128'(0));
        end else begin
          chk("pc_o", 128'(bus.pc_o), 128'(exp_wr_pc.pop_front()));
          chk("cyphertext_d_o", bus.cyphertext_d_o, exp_wr_ct.pop_front());
        end
      end
      prev_fin = bus.finish_d_o;
      if (done) begin
        done_cyc = cyc;
        if (exp_done == 0) chk("unexpected done_o", 128'(1), 128'(0));
        else exp_done--;
      end
    end else begin
      prev_fin = 1'b0;
    end
  end

  // ---------------- stimulus helpers
  task automatic pulse_start(input int n);
    @(negedge clk);
    start = 1'b1;
    num_blocks = (AW + 1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_sig(input bit want_error, input int budget, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((!want_error && done) || (want_error && error)) begin
        seen = 1'b1;
        break;
      end
    end
    chki({name, " reached"}, int'(seen), 1);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " pt_addr_o"},       128'(bus.pt_addr_o), 128'(0));
    chk({name, " pt_rd_o"},         128'(bus.pt_rd_o), 128'(0));
    chk({name, " aes_start_o"},     128'(bus.aes_start_o), 128'(0));
    chk({name, " aes_plaintext_o"}, bus.aes_plaintext_o, 128'(0));
    chk({name, " pc_o"},            128'(bus.pc_o), 128'(0));
    chk({name, " finish_d_o"},      128'(bus.finish_d_o), 128'(0));
    chk({name, " cyphertext_d_o"},  bus.cyphertext_d_o, 128'(0));
    chk({name, " busy_o"},          128'(busy), 128'(0));
    chk({name, " done_o"},          128'(done), 128'(0));
    chk({name, " error_o"},         128'(error), 128'(0));
  endtask

  int n_wr0;

  initial begin
    for (int i = 0; i < int'(MS); i++) pt_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    pt_mem[0] = PT0;

    // power-on reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("por");
    rst_n = 1'b1;

    // reset asserted while the core is still busy
    aes_never = 1'b1;
    expect_stall();
    pulse_start(1);
    repeat (10) @(negedge clk);
    chk("busy_o in WAIT", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid-wait reset");
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    aes_never = 1'b0;

    // single block, core latency 10, reference vector
    aes_lat = 10;
    fin_cyc.delete();
    expect_run(1);
    pulse_start(1);
    wait_sig(1'b0, 100, "single done_o");
    chki("single write count", fin_cyc.size(), 1);
    chki("single launch-to-write", fin_cyc[0] - launch_cyc, 11);
    chki("single write-to-done", done_cyc - fin_cyc[0], 1);
    chk("single pc_o", 128'(bus.pc_o), 128'(0));
    chk("single cyphertext literal", bus.cyphertext_d_o, CT0);
    check_drained("single");

    // three blocks, latency 5, stray start mid-run
    aes_lat = 5;
    fin_cyc.delete();
    expect_run(3);
    pulse_start(3);
    repeat (6) @(negedge clk);
    start = 1'b1;
    num_blocks = (AW + 1)'(7);
    @(negedge clk);
    start = 1'b0;
    chk("three busy_o", 128'(busy), 128'(1));
    wait_sig(1'b0, 200, "three done_o");
    chki("three write count", fin_cyc.size(), 3);
    chki("three spacing 0-1", fin_cyc[1] - fin_cyc[0], 9);
    chki("three spacing 1-2", fin_cyc[2] - fin_cyc[1], 9);
    chk("three last pc_o", 128'(last_wr_pc), 128'(2));
    check_drained("three");

    // core done while idle must not write
    n_wr0 = n_wr;
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chki("stray done writes", n_wr - n_wr0, 0);
    chk("stray done busy_o", 128'(busy), 128'(0));

    // zero-block run
    expect_run(0);
    pulse_start(0);
    @(negedge clk);
    chk("zero done_o", 128'(done), 128'(1));
    chk("zero busy_o in DONE", 128'(busy), 128'(1));
    @(negedge clk);
    chk("zero done_o falls", 128'(done), 128'(0));
    chk("zero busy_o idle", 128'(busy), 128'(0));
    check_drained("zero");

    // watchdog: core never answers
    aes_never = 1'b1;
    n_wr0 = n_wr;
    expect_stall();
    pulse_start(2);
    wait_sig(1'b1, 200, "timeout error_o");
    chki("launch-to-error cycles", cyc - launch_cyc, 64);
    chk("busy_o in ERROR", 128'(busy), 128'(1));
    repeat (5) @(negedge clk);
    chk("error_o sticky", 128'(error), 128'(1));
    chki("timeout writes", n_wr - n_wr0, 0);
    check_drained("timeout");

    // restart from ERROR
    aes_never = 1'b0;
    aes_lat = 3;
    expect_run(1);
    pulse_start(1);
    @(negedge clk);
    chk("restart clears error_o", 128'(error), 128'(0));
    wait_sig(1'b0, 100, "restart done_o");
    chk("restart pc_o", 128'(last_wr_pc), 128'(0));
    check_drained("restart");

    // done in the same cycle the watchdog expires
    aes_lat = int'(TO) - 1;
    expect_run(1);
    pulse_start(1);
    wait_sig(1'b0, 200, "late-done done_o");
    chk("late-done error_o", 128'(error), 128'(0));
    check_drained("late-done");

    // oversize request clamps to the buffer depth
    aes_lat = 1;
    n_wr0 = n_wr;
    expect_run(int'(MS) + 5);
    pulse_start(int'(MS) + 5);
    wait_sig(1'b0, 3000, "clamp done_o");
    chki("clamp write count", n_wr - n_wr0, 256);
    chk("clamp last pc_o", 128'(last_wr_pc), 128'(255));
    repeat (2) @(negedge clk);
    chk("clamp pc_o holds", 128'(bus.pc_o), 128'(255));
    check_drained("clamp");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
